pipeline_hazard_ctrl: RTL and testbench

//  Central producer of the freeze/flush controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_if.sv | 58 +++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard controller
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Architectural register index width (16 GPRs)
    localparam int unsigned c_REG_W     = 4;
    // Default performance counter width
    localparam int unsigned c_CNT_W_DEF = 16;

    // Memory-wait FSM encoding
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Pipeline-side bundle of hazard inputs and freeze/flush outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W_DEF
);
    // Pipeline status towards the controller
    logic               forward_en;
    logic [c_REG_W-1:0] id_src1;
    logic [c_REG_W-1:0] id_src2;
    logic               id_two_src;
    logic               id_src1_valid;
    logic [c_REG_W-1:0] exe_dest;
    logic               exe_wb_en;
    logic               exe_mem_r_en;
    logic [c_REG_W-1:0] mem_dest;
    logic               mem_wb_en;
    logic               mem_req;
    logic               sram_ready;
    logic               branch_taken;

    // Controls back to the pipeline registers
    logic               pc_freeze;
    logic               if_id_freeze;
    logic               if_id_flush;
    logic               id_ex_freeze;
    logic               id_ex_flush;
    logic               ex_mem_freeze;
    logic               mem_wb_freeze;
    logic               mem_timeout;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    // Pipeline side
    modport master (
        output forward_en, id_src1, id_src2, id_two_src, id_src1_valid,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               mem_req, sram_ready, branch_taken,
        input  pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
               ex_mem_freeze, mem_wb_freeze, mem_timeout, stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  forward_en, id_src1, id_src2, id_two_src, id_src1_valid,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               mem_req, sram_ready, branch_taken,
        output pc_freeze, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush,
               ex_mem_freeze, mem_wb_freeze, mem_timeout, stall_cnt, flush_cnt
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_hazard_detect
//  Description : Combinational RAW compare of ID sources against EXE/MEM dests
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  wire logic               forward_en_i,
    input  wire logic [c_REG_W-1:0] id_src1_i,
    input  wire logic [c_REG_W-1:0] id_src2_i,
    input  wire logic               id_two_src_i,
    input  wire logic               id_src1_valid_i,
    input  wire logic [c_REG_W-1:0] exe_dest_i,
    input  wire logic               exe_wb_en_i,
    input  wire logic               exe_mem_r_en_i,
    input  wire logic [c_REG_W-1:0] mem_dest_i,
    input  wire logic               mem_wb_en_i,
    output logic                    hazard_o
);

    logic w_match_exe;
    logic w_match_mem;

    // Source/destination matches, only for operands the ID instruction really reads
    always_comb begin
        w_match_exe = (id_src1_valid_i && (id_src1_i == exe_dest_i)) ||
                      (id_two_src_i    && (id_src2_i == exe_dest_i));
        w_match_mem = (id_src1_valid_i && (id_src1_i == mem_dest_i)) ||
                      (id_two_src_i    && (id_src2_i == mem_dest_i));
    end

    // With forwarding only a load in EXE cannot be bypassed in time
    always_comb begin
        if (forward_en_i) begin
            hazard_o = exe_mem_r_en_i && exe_wb_en_i && w_match_exe;
        end else begin
            hazard_o = (exe_wb_en_i && w_match_exe) || (mem_wb_en_i && w_match_mem);
        end
    end

endmodule : pipeline_hazard_ctrl_hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Freeze/flush generation, SRAM wait FSM with timeout and
//                saturating stall/flush performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = c_CNT_W_DEF
)(
    input  wire logic              clk,
    input  wire logic              rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam int unsigned c_WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);

    hz_state_t           state_q, state_d;
    logic [c_WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_q;

    logic w_hazard;
    logic w_mem_stall;
    logic w_pc_freeze;
    logic w_if_id_freeze;
    logic w_if_id_flush;
    logic w_id_ex_freeze;
    logic w_id_ex_flush;
    logic w_ex_mem_freeze;
    logic w_mem_wb_freeze;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .forward_en_i    (bus.forward_en),
        .id_src1_i       (bus.id_src1),
        .id_src2_i       (bus.id_src2),
        .id_two_src_i    (bus.id_two_src),
        .id_src1_valid_i (bus.id_src1_valid),
        .exe_dest_i      (bus.exe_dest),
        .exe_wb_en_i     (bus.exe_wb_en),
        .exe_mem_r_en_i  (bus.exe_mem_r_en),
        .mem_dest_i      (bus.mem_dest),
        .mem_wb_en_i     (bus.mem_wb_en),
        .hazard_o        (w_hazard)
    );

    // FSM, wait counter and sticky timeout state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next state and memory stall; the timeout cycle itself is released
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        w_mem_stall   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (bus.mem_req && !bus.sram_ready) begin
                    state_d     = ST_MEM_WAIT;
                    wait_cnt_d  = c_WAIT_W'(1);
                    w_mem_stall = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.sram_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == c_WAIT_MAX) begin
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d  = wait_cnt_q + c_WAIT_W'(1);
                    w_mem_stall = 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Priority mux: memory stall, then branch flush, then data-hazard bubble
    always_comb begin
        w_pc_freeze     = 1'b0;
        w_if_id_freeze  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_freeze  = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_freeze = 1'b0;
        w_mem_wb_freeze = 1'b0;
        if (rst) begin
            // all controls held low while in reset
        end else if (w_mem_stall) begin
            w_pc_freeze     = 1'b1;
            w_if_id_freeze  = 1'b1;
            w_id_ex_freeze  = 1'b1;
            w_ex_mem_freeze = 1'b1;
            w_mem_wb_freeze = 1'b1;
        end else if (bus.branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_hazard) begin
            w_pc_freeze    = 1'b1;
            w_if_id_freeze = 1'b1;
            w_id_ex_flush  = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (w_pc_freeze && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (w_if_id_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_freeze     = w_pc_freeze;
    assign bus.if_id_freeze  = w_if_id_freeze;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_freeze  = w_id_ex_freeze;
    assign bus.id_ex_flush   = w_id_ex_flush;
    assign bus.ex_mem_freeze = w_ex_mem_freeze;
    assign bus.mem_wb_freeze = w_mem_wb_freeze;
    assign bus.mem_timeout   = mem_timeout_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Scoreboard bench for the pipeline hazard controller
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_TO    = 15;
    localparam int c_CNT_W = 16;
    localparam int c_SAT   = 65535;

    typedef struct packed {
        bit       forward_en;
        bit [3:0] id_src1;
        bit [3:0] id_src2;
        bit       id_two_src;
        bit       id_src1_valid;
        bit [3:0] exe_dest;
        bit       exe_wb_en;
        bit       exe_mem_r_en;
        bit [3:0] mem_dest;
        bit       mem_wb_en;
        bit       mem_req;
        bit       sram_ready;
        bit       branch_taken;
    } stim_t;

    typedef struct packed {
        bit [6:0]  ctl;   // {pc, if_id_frz, if_id_fl, id_ex_frz, id_ex_fl, ex_mem_frz, mem_wb_frz}
        bit        to;
        bit [15:0] stall;
        bit [15:0] flush;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    // reference model state
    bit m_wait;
    int m_cnt;
    bit m_to;
    int m_stall;
    int m_flush;

    pipeline_hazard_ctrl_if #(.CNT_W(c_CNT_W)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(c_TO), .CNT_W(c_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hazard(input stim_t s);
        bit e;
        bit m;
        e = (s.id_src1_valid && s.id_src1 == s.exe_dest) || (s.id_two_src && s.id_src2 == s.exe_dest);
        m = (s.id_src1_valid && s.id_src1 == s.mem_dest) || (s.id_two_src && s.id_src2 == s.mem_dest);
        if (s.forward_en) return s.exe_mem_r_en && s.exe_wb_en && e;
        return (s.exe_wb_en && e) || (s.mem_wb_en && m);
    endfunction

    task automatic drive(input stim_t s);
        bus.forward_en    = s.forward_en;
        bus.id_src1       = s.id_src1;
        bus.id_src2       = s.id_src2;
        bus.id_two_src    = s.id_two_src;
        bus.id_src1_valid = s.id_src1_valid;
        bus.exe_dest      = s.exe_dest;
        bus.exe_wb_en     = s.exe_wb_en;
        bus.exe_mem_r_en  = s.exe_mem_r_en;
        bus.mem_dest      = s.mem_dest;
        bus.mem_wb_en     = s.mem_wb_en;
        bus.mem_req       = s.mem_req;
        bus.sram_ready    = s.sram_ready;
        bus.branch_taken  = s.branch_taken;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.exe_dest = 4'd14;
        s.mem_dest = 4'd15;
        return s;
    endfunction

    function automatic void model_reset();
        m_wait  = 0;
        m_cnt   = 0;
        m_to    = 0;
        m_stall = 0;
        m_flush = 0;
    endfunction

    // One clock cycle: drive at negedge, push expectation, compare, advance model
    task automatic step(input stim_t s, input bit chk_en);
        exp_t e;
        exp_t g;
        bit   stall;
        @(negedge clk);
        drive(s);
        if (!m_wait) stall = s.mem_req && !s.sram_ready;
        else         stall = !s.sram_ready && (m_cnt != c_TO);
        if (stall)                   e.ctl = 7'b1101011;
        else if (s.branch_taken)     e.ctl = 7'b0010100;
        else if (model_hazard(s))    e.ctl = 7'b1100100;
        else                         e.ctl = 7'b0000000;
        e.to    = m_to;
        e.stall = 16'(m_stall);
        e.flush = 16'(m_flush);
        sb_q.push_back(e);
        #2;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            g.ctl = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_freeze,
                     bus.id_ex_flush, bus.ex_mem_freeze, bus.mem_wb_freeze};
            g.to    = bus.mem_timeout;
            g.stall = bus.stall_cnt;
            g.flush = bus.flush_cnt;
            if (chk_en) begin
                check("ctl", 64'(g.ctl), 64'(e.ctl));
                check("mem_timeout", 64'(g.to), 64'(e.to));
                check("stall_cnt", 64'(g.stall), 64'(e.stall));
                check("flush_cnt", 64'(g.flush), 64'(e.flush));
            end
        end
        // advance model as of the coming posedge
        if (e.ctl[6] && m_stall < c_SAT) m_stall++;
        if (e.ctl[4] && m_flush < c_SAT) m_flush++;
        if (!m_wait) begin
            if (s.mem_req && !s.sram_ready) begin m_wait = 1; m_cnt = 1; end
        end else if (s.sram_ready) begin
            m_wait = 0; m_cnt = 0;
        end else if (m_cnt == c_TO) begin
            m_wait = 0; m_cnt = 0; m_to = 1;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        stim_t s;
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        // Reset: hazard and stall inputs present but all controls low
        rst = 1'b1;
        s = idle();
        s.id_src1_valid = 1; s.id_src1 = 3; s.exe_dest = 3; s.exe_wb_en = 1;
        s.mem_req = 1; s.branch_taken = 1;
        drive(s);
        #2;
        check("rst_ctl", 64'({bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_freeze,
                              bus.id_ex_flush, bus.ex_mem_freeze, bus.mem_wb_freeze}), 64'd0);
        check("rst_stall", 64'(bus.stall_cnt), 64'd0);
        check("rst_flush", 64'(bus.flush_cnt), 64'd0);
        check("rst_to", 64'(bus.mem_timeout), 64'd0);
        drive(idle());
        @(negedge clk);
        rst = 1'b0;

        // Non-forwarding RAW against EXE: one bubble cycle
        s = idle(); s.id_src1_valid = 1; s.id_src1 = 3; s.exe_dest = 3; s.exe_wb_en = 1;
        step(s, 1);
        step(idle(), 1);
        // Non-forwarding RAW against MEM via src2
        s = idle(); s.id_two_src = 1; s.id_src2 = 7; s.mem_dest = 7; s.mem_wb_en = 1;
        step(s, 1);
        // Source not read: no hazard
        s.id_two_src = 0;
        step(s, 1);

        // Forwarding: ALU result no stall, load-use stalls
        s = idle(); s.forward_en = 1; s.id_src1_valid = 1; s.id_src1 = 3; s.exe_dest = 3; s.exe_wb_en = 1;
        step(s, 1);
        s.exe_mem_r_en = 1;
        step(s, 1);
        s = idle(); s.forward_en = 1; s.id_src1_valid = 1; s.id_src1 = 5; s.mem_dest = 5; s.mem_wb_en = 1;
        step(s, 1);

        // SRAM wait: ready low 4 cycles then high
        s = idle(); s.mem_req = 1;
        for (int i = 0; i < 4; i++) step(s, 1);
        s.sram_ready = 1;
        step(s, 1);
        step(idle(), 1);

        // Branch during 3-cycle wait: flush only on release
        s = idle(); s.mem_req = 1; s.branch_taken = 1;
        s.id_src1_valid = 1; s.id_src1 = 2; s.exe_dest = 2; s.exe_wb_en = 1;
        for (int i = 0; i < 3; i++) step(s, 1);
        s.sram_ready = 1;
        step(s, 1);
        step(idle(), 1);

        // Timeout: ready held low, freeze drops after MEM_TIMEOUT cycles
        s = idle(); s.mem_req = 1;
        for (int i = 0; i < c_TO; i++) step(s, 1);
        s.mem_req = 0;
        step(s, 1);
        for (int i = 0; i < 3; i++) step(idle(), 1);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            s = idle();
            s.forward_en    = 1'($urandom_range(0, 1));
            s.id_src1       = 4'($urandom_range(0, 3));
            s.id_src2       = 4'($urandom_range(0, 3));
            s.id_two_src    = 1'($urandom_range(0, 1));
            s.id_src1_valid = 1'($urandom_range(0, 1));
            s.exe_dest      = 4'($urandom_range(0, 3));
            s.exe_wb_en     = 1'($urandom_range(0, 1));
            s.exe_mem_r_en  = 1'($urandom_range(0, 1));
            s.mem_dest      = 4'($urandom_range(0, 3));
            s.mem_wb_en     = 1'($urandom_range(0, 1));
            s.mem_req       = ($urandom_range(0, 3) == 0);
            s.sram_ready    = 1'($urandom_range(0, 1));
            s.branch_taken  = ($urandom_range(0, 4) == 0);
            step(s, 1);
        end
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.sram_ready = 1;
            step(s, 1);
        end

        // Reset asserted mid-wait: controls drop immediately, state cleared
        s = idle(); s.mem_req = 1;
        step(s, 1);
        step(s, 1);
        @(negedge clk);
        drive(s);
        #1 rst = 1'b1;
        #1;
        check("rstw_ctl", 64'({bus.pc_freeze, bus.if_id_freeze, bus.id_ex_freeze,
                               bus.ex_mem_freeze, bus.mem_wb_freeze}), 64'd0);
        check("rstw_stall", 64'(bus.stall_cnt), 64'd0);
        check("rstw_to", 64'(bus.mem_timeout), 64'd0);
        drive(idle());
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(idle(), 1);
        s = idle(); s.mem_req = 1;
        step(s, 1);     // FSM back in RUN: stall starts from a fresh wait
        s.sram_ready = 1;
        step(s, 1);

        // Long data-hazard stall: stall_cnt saturates at all-ones
        s = idle(); s.id_src1_valid = 1; s.id_src1 = 9; s.exe_dest = 9; s.exe_wb_en = 1;
        for (int i = 0; i < c_SAT + 3; i++) step(s, (i >= c_SAT - 2));
        step(idle(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
